// File: rtl/mem_store_buffer_pkg.sv
// Common types and sizing helpers for the posted-store buffer.
package mem_store_buffer_pkg;
`include "headfile.v"

    localparam int unsigned SbDepth = `SB_DEPTH;
    localparam int unsigned SbAw    = `AW;
    localparam int unsigned SbDw    = `DW;

    typedef enum logic [1:0] {
        DrainNone,
        DrainIdle,
        DrainForced
    } drain_e;

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/headfile.v
// Shared build-wide sizes for the data-memory path.
`ifndef HEADFILE_V
`define HEADFILE_V
`define AW       8
`define DW       16
`define SB_DEPTH 4
`endif

// File: rtl/sb_fwd_match.sv
// Youngest-match selector: scans valid entries oldest to youngest from head.
module sb_fwd_match #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 8,
    localparam int unsigned IW   = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]         valid,
    input  logic [DEPTH-1:0][AW-1:0] addr,
    input  logic [AW-1:0]            ld_addr,
    input  logic [IW-1:0]            head,
    output logic                     hit,
    output logic [IW-1:0]            hit_idx
);

    logic [IW-1:0] idx;

    // Later (younger) matches overwrite earlier ones.
    always_comb begin
        hit     = 1'b0;
        hit_idx = head;
        idx     = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + IW'(i);
            if (valid[idx] && (addr[idx] == ld_addr)) begin
                hit     = 1'b1;
                hit_idx = idx;
            end
        end
    end

endmodule

// File: rtl/mem_store_buffer.sv
// Posted-store buffer in front of the single-port data memory, with load forwarding.
module mem_store_buffer
    import mem_store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = SbDepth,
    parameter int unsigned AW    = SbAw,
    parameter int unsigned DW    = SbDw,
    localparam int unsigned CW   = cnt_width(DEPTH)
) (
    input  logic          mem_clk,
    input  logic          rst,
    input  logic          st_valid,
    input  logic [AW-1:0] st_addr,
    input  logic [DW-1:0] st_data,
    output logic          st_ready,
    input  logic          ld_req,
    input  logic [AW-1:0] ld_addr,
    output logic [DW-1:0] ld_rdata,
    output logic          ld_stall,
    output logic          dm_dwe,
    output logic [AW-1:0] dm_addr,
    output logic [DW-1:0] dm_wdata,
    input  logic [DW-1:0] dm_rdata,
    output logic          sb_empty,
    output logic [CW-1:0] sb_count
);

    localparam int unsigned IW = $clog2(DEPTH);

    logic [DEPTH-1:0][AW-1:0] addr_q;
    logic [DEPTH-1:0][DW-1:0] data_q;
    logic [IW-1:0]            head_q, head_d;
    logic [IW-1:0]            tail_q, tail_d;
    logic [CW-1:0]            count_q, count_d;

    logic       full;
    logic       push;
    logic       pop;
    drain_e     drain_src;
    logic [DEPTH-1:0] valid;
    logic       hit;
    logic [IW-1:0] hit_idx;

    assign full     = (count_q == CW'(DEPTH));
    assign st_ready = !full;
    assign push     = st_valid && st_ready;
    assign sb_empty = (count_q == '0);
    assign sb_count = count_q;

    always_comb begin
        drain_src = DrainNone;
        if (full && ld_req) begin
            drain_src = DrainForced;
        end else if (!sb_empty && !ld_req) begin
            drain_src = DrainIdle;
        end
    end

    assign pop      = (drain_src != DrainNone);
    assign ld_stall = (drain_src == DrainForced);
    assign dm_dwe   = pop;
    assign dm_addr  = pop ? addr_q[head_q] : ld_addr;
    assign dm_wdata = pop ? data_q[head_q] : st_data;

    // Slot is live when its distance from head is below the occupancy.
    always_comb begin
        valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid[i] = (CW'(IW'(i) - head_q) < count_q);
        end
    end

    sb_fwd_match #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fwd (
        .valid   (valid),
        .addr    (addr_q),
        .ld_addr (ld_addr),
        .head    (head_q),
        .hit     (hit),
        .hit_idx (hit_idx)
    );

    assign ld_rdata = hit ? data_q[hit_idx] : dm_rdata;

    always_comb begin
        head_d  = pop  ? head_q + 1'b1 : head_q;
        tail_d  = push ? tail_q + 1'b1 : tail_q;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload needs no reset: occupancy gates every read of it.
    always_ff @(posedge mem_clk) begin
        if (push) begin
            addr_q[tail_q] <= st_addr;
            data_q[tail_q] <= st_data;
        end
    end

endmodule

// File: tb/tb_mem_store_buffer.sv
// Directed bench for mem_store_buffer with a behavioural 256x16 data memory.
module tb_mem_store_buffer;

    logic        mem_clk;
    logic        rst;
    logic        st_valid;
    logic [7:0]  st_addr;
    logic [15:0] st_data;
    logic        st_ready;
    logic        ld_req;
    logic [7:0]  ld_addr;
    logic [15:0] ld_rdata;
    logic        ld_stall;
    logic        dm_dwe;
    logic [7:0]  dm_addr;
    logic [15:0] dm_wdata;
    logic [15:0] dm_rdata;
    logic        sb_empty;
    logic [2:0]  sb_count;

    logic [15:0] dmem [0:255];

    int passed = 0;
    int total  = 0;

    mem_store_buffer dut (
        .mem_clk  (mem_clk),
        .rst      (rst),
        .st_valid (st_valid),
        .st_addr  (st_addr),
        .st_data  (st_data),
        .st_ready (st_ready),
        .ld_req   (ld_req),
        .ld_addr  (ld_addr),
        .ld_rdata (ld_rdata),
        .ld_stall (ld_stall),
        .dm_dwe   (dm_dwe),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata),
        .sb_empty (sb_empty),
        .sb_count (sb_count)
    );

    initial mem_clk = 1'b0;
    always #5 mem_clk = ~mem_clk;

    always @(posedge mem_clk) begin
        if (dm_dwe) dmem[dm_addr] <= dm_wdata;
    end
    assign dm_rdata = dmem[dm_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) dmem[i] = 16'h0000;
        dmem[0] = 16'hfffe;
        rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0;
        ld_req = 1'b0; ld_addr = '0;
        #2;
        chk("rst_st_ready", st_ready, 1);
        chk("rst_sb_empty", sb_empty, 1);
        chk("rst_sb_count", sb_count, 0);
        chk("rst_dm_dwe", dm_dwe, 0);
        chk("rst_ld_stall", ld_stall, 0);
        @(negedge mem_clk); rst = 1'b0;

        // 1: raw load
        @(negedge mem_clk); ld_req = 1'b1; ld_addr = 8'h00; #1;
        chk("t1_rdata", ld_rdata, 16'hfffe);
        chk("t1_dwe", dm_dwe, 0);
        chk("t1_stall", ld_stall, 0);
        chk("t1_dm_addr", dm_addr, 8'h00);

        // 2: single store, forward, then drain
        @(negedge mem_clk); st_valid = 1'b1; st_addr = 8'h05; st_data = 16'h1234;
        ld_addr = 8'h05; #1;
        chk("t2_not_fwd_same_cycle", ld_rdata, 16'h0000);
        @(negedge mem_clk); st_valid = 1'b0; #1;
        chk("t2_fwd", ld_rdata, 16'h1234);
        chk("t2_hold_dwe", dm_dwe, 0);
        chk("t2_count", sb_count, 1);
        @(negedge mem_clk); ld_req = 1'b0; #1;
        chk("t2_drain_dwe", dm_dwe, 1);
        chk("t2_drain_addr", dm_addr, 8'h05);
        chk("t2_drain_data", dm_wdata, 16'h1234);
        @(negedge mem_clk); #1;
        chk("t2_empty", sb_empty, 1);
        chk("t2_idle_dwe", dm_dwe, 0);
        chk("t2_dmem5", dmem[5], 16'h1234);

        // 3: same-address stores, youngest forwards, retire in order
        @(negedge mem_clk); ld_req = 1'b1; ld_addr = 8'h10;
        st_valid = 1'b1; st_addr = 8'h10; st_data = 16'haaaa;
        @(negedge mem_clk); st_data = 16'hbbbb;
        @(negedge mem_clk); st_valid = 1'b0; #1;
        chk("t3_fwd_young", ld_rdata, 16'hbbbb);
        chk("t3_count", sb_count, 2);
        @(negedge mem_clk); ld_req = 1'b0; #1;
        chk("t3_drain0_addr", dm_addr, 8'h10);
        chk("t3_drain0_data", dm_wdata, 16'haaaa);
        @(negedge mem_clk); #1;
        chk("t3_drain1_dwe", dm_dwe, 1);
        chk("t3_drain1_data", dm_wdata, 16'hbbbb);
        chk("t3_dmem16_mid", dmem[16], 16'haaaa);
        @(negedge mem_clk); #1;
        chk("t3_empty", sb_empty, 1);
        chk("t3_dmem16", dmem[16], 16'hbbbb);

        // 4: fill under a held load, forced drain
        ld_req = 1'b1; ld_addr = 8'h20;
        for (int i = 0; i < 4; i++) begin
            @(negedge mem_clk); st_valid = 1'b1;
            st_addr = 8'h20 + 8'(i); st_data = 16'h4000 + 16'(i); #1;
            chk("t4_ready_filling", st_ready, 1);
        end
        @(negedge mem_clk); st_addr = 8'h24; st_data = 16'hdead; #1;
        chk("t4_full_count", sb_count, 4);
        chk("t4_full_ready", st_ready, 0);
        chk("t4_stall", ld_stall, 1);
        chk("t4_forced_dwe", dm_dwe, 1);
        chk("t4_forced_addr", dm_addr, 8'h20);
        chk("t4_forced_data", dm_wdata, 16'h4000);
        chk("t4_fwd_stalled", ld_rdata, 16'h4000);
        @(negedge mem_clk); st_valid = 1'b0; ld_addr = 8'h24; #1;
        chk("t4_after_count", sb_count, 3);
        chk("t4_after_ready", st_ready, 1);
        chk("t4_after_stall", ld_stall, 0);
        chk("t4_after_dwe", dm_dwe, 0);
        chk("t4_rejected_store", ld_rdata, 16'h0000);
        chk("t4_dmem20", dmem[8'h20], 16'h4000);

        // 5: push and pop on the same edge
        @(negedge mem_clk); ld_req = 1'b0; #1;
        chk("t5_pre_drain_addr", dm_addr, 8'h21);
        @(negedge mem_clk); st_valid = 1'b1; st_addr = 8'h30; st_data = 16'h5555; #1;
        chk("t5_pre_count", sb_count, 2);
        chk("t5_drain_dwe", dm_dwe, 1);
        chk("t5_drain_addr", dm_addr, 8'h22);
        @(negedge mem_clk); st_valid = 1'b0; ld_req = 1'b1; ld_addr = 8'h30; #1;
        chk("t5_count_kept", sb_count, 2);
        chk("t5_fwd_new", ld_rdata, 16'h5555);
        chk("t5_dmem22", dmem[8'h22], 16'h4002);

        // 6: asynchronous reset mid-stream
        @(negedge mem_clk); st_valid = 1'b1; st_addr = 8'h31; st_data = 16'h6666;
        ld_addr = 8'h23; #1;
        chk("t6_fwd_23", ld_rdata, 16'h4003);
        @(negedge mem_clk); st_valid = 1'b0; ld_req = 1'b0; #1;
        chk("t6_count3", sb_count, 3);
        chk("t6_pre_rst_dwe", dm_dwe, 1);
        #1 rst = 1'b1; #1;
        chk("t6_rst_count", sb_count, 0);
        chk("t6_rst_empty", sb_empty, 1);
        chk("t6_rst_dwe", dm_dwe, 0);
        chk("t6_rst_ready", st_ready, 1);
        @(negedge mem_clk); rst = 1'b0; ld_req = 1'b1; ld_addr = 8'h23; #1;
        chk("t6_raw_23", ld_rdata, 16'h0000);
        chk("t6_raw_empty", sb_empty, 1);
        @(negedge mem_clk); ld_addr = 8'h05; #1;
        chk("t6_raw_05", ld_rdata, 16'h1234);
        @(negedge mem_clk); ld_addr = 8'h10; #1;
        chk("t6_raw_10", ld_rdata, 16'hbbbb);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
